// File: rtl/err_test_pkg.sv
// ---------------------------------------------------------------------------
// err_test_pkg
// Shared definitions for the err_test_ctrl run controller:
//   - state_e : FSM state encoding (also driven out on the 'state' port)
//   - BYTE_W  : width of the GMII/MAC receive byte
//   - CNT_W   : width of the detect_errors counters and result registers
// ---------------------------------------------------------------------------
package err_test_pkg;

    localparam int BYTE_W  = 8;
    localparam int CNT_W   = 32;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_HOLD  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/pkt_gate.sv
// ---------------------------------------------------------------------------
// pkt_gate
// Whole-packet gate between the MAC receive stream and detect_errors.
// A packet may only be let through if the gate is enabled on its first byte
// (the rising edge of rx_en); once open, the gate stays open until rx_en
// falls, so packets are never cut or joined mid-stream.
//
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   enable_i       FSM allows a new packet to open the gate this cycle
//   rx_en_i        byte-valid from MAC
//   rx_data_i      byte from MAC
//   rx_en_o        registered, gated byte-valid (1 cycle latency)
//   rx_data_o      registered, gated byte (0 when rx_en_o is 0)
//   gate_open_o    a byte is passing through the gate this cycle
//   start_fwd_o    pulse: a packet start edge opened the gate this cycle
//   rx_start_o     pulse: raw packet start edge, whether forwarded or not
// ---------------------------------------------------------------------------
module pkt_gate
    import err_test_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              rx_en_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    output logic              rx_en_o,
    output logic [BYTE_W-1:0] rx_data_o,
    output logic              gate_open_o,
    output logic              start_fwd_o,
    output logic              rx_start_o
);

    logic              prev_en_q;
    logic              en_out_q;
    logic [BYTE_W-1:0] data_out_q;
    logic              pass;

    // The registered output valid doubles as the "gate was open last cycle"
    // state: a byte keeps passing while the previous one passed and rx_en
    // is still high, or when a new packet starts while enabled.
    assign rx_start_o  = rx_en_i & ~prev_en_q;
    assign start_fwd_o = rx_start_o & enable_i;
    assign pass        = rx_en_i & (en_out_q | start_fwd_o);
    assign gate_open_o = pass;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_en_q  <= 1'b0;
            en_out_q   <= 1'b0;
            data_out_q <= '0;
        end else begin
            prev_en_q  <= rx_en_i;
            en_out_q   <= pass;
            data_out_q <= pass ? rx_data_i : '0;
        end
    end

    assign rx_en_o   = en_out_q;
    assign rx_data_o = data_out_q;

endmodule

// File: rtl/err_test_ctrl.sv
// ---------------------------------------------------------------------------
// err_test_ctrl
// Run controller for the detect_errors receive-side error counter. A run
// resets the detector, waits for an inter-packet gap, forwards exactly
// PKT_TARGET whole packets, lets the detector settle and latches its totals.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, abort             one-cycle run control pulses
//   rx_en_in, rx_data_in     MAC receive stream
//   rx_en_out, rx_data_out   gated stream to detect_errors (1 cycle latency)
//   det_rst                  detect_errors reset (also high during rst)
//   det_count, det_ok        detect_errors totals
//   pkt_fwd                  packets forwarded this run (saturates)
//   result_count/ok/err      latched run totals, err = count - ok
//   busy, done, aborted      run status; done pulses on entry to DONE
//   state                    current FSM state
//
// Build option: define RUN_TIMEOUT_EN to add an idle-gap watchdog that ends
// the run (aborted, partial results latched) after TIMEOUT_CYCLES without a
// packet start in ARM or RUN. Without it TIMEOUT_CYCLES is unused.
// CLEAR_CYCLES and SETTLE_CYCLES must both be at least 1.
// ---------------------------------------------------------------------------
module err_test_ctrl
    import err_test_pkg::*;
#(
    parameter int PKT_TARGET     = 300,
    parameter int CLEAR_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              rx_en_in,
    input  logic [BYTE_W-1:0] rx_data_in,
    output logic              rx_en_out,
    output logic [BYTE_W-1:0] rx_data_out,
    output logic              det_rst,
    input  logic [CNT_W-1:0]  det_count,
    input  logic [CNT_W-1:0]  det_ok,
    output logic [15:0]       pkt_fwd,
    output logic [CNT_W-1:0]  result_count,
    output logic [CNT_W-1:0]  result_ok,
    output logic [CNT_W-1:0]  result_err,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [2:0]        state
);

    localparam logic [15:0]      TARGET      = 16'(PKT_TARGET);
    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [15:0]      pkt_fwd_q, pkt_fwd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic [CNT_W-1:0] res_ok_q, res_ok_d;
    logic             aborted_q, aborted_d;
    logic             done_q;

    logic             gate_en;
    logic             gate_open;
    logic             start_fwd;
    logic             rx_start;
    logic             timeout_hit;

    // New packets may only open the gate while the run is collecting.
    assign gate_en = (state_q == ST_RUN);

    pkt_gate u_gate (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (gate_en),
        .rx_en_i     (rx_en_in),
        .rx_data_i   (rx_data_in),
        .rx_en_o     (rx_en_out),
        .rx_data_o   (rx_data_out),
        .gate_open_o (gate_open),
        .start_fwd_o (start_fwd),
        .rx_start_o  (rx_start)
    );

`ifdef RUN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wd_q, wd_d;

    // Watchdog measures the gap since the last packet start (or since the
    // run was armed); it saturates so it can never wrap into a false restart.
    always_comb begin
        wd_d = wd_q;
        if (rx_start || (state_d == ST_ARM && state_q != ST_ARM)) begin
            wd_d = '0;
        end else if (wd_q != WD_LAST) begin
            wd_d = wd_q + 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout_hit = (wd_q == WD_LAST) && !rx_start;
`else
    logic unused_wd;
    assign unused_wd   = ^{rx_start, 32'(TIMEOUT_CYCLES)};
    assign timeout_hit = 1'b0;
`endif

    // Run sequencing. cnt_q is shared by CLEAR and HOLD and returns to zero
    // whenever it is not being advanced, so each of those states starts
    // counting from zero on entry.
    always_comb begin
        state_d     = state_q;
        pkt_fwd_d   = pkt_fwd_q;
        cnt_d       = '0;
        res_count_d = res_count_q;
        res_ok_d    = res_ok_q;
        aborted_d   = aborted_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pkt_fwd_d = '0;
                    aborted_d = 1'b0;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == CLEAR_LAST) begin
                    state_d = ST_ARM;
                end else begin
                    cnt_d = cnt_q + 1;
                end
            end
            ST_ARM: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (timeout_hit) begin
                    aborted_d = 1'b1;
                    state_d   = ST_HOLD;
                end else if (!rx_en_in) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start_fwd) begin
                    if (pkt_fwd_q != TARGET) begin
                        pkt_fwd_d = pkt_fwd_q + 16'd1;
                    end
                    if (pkt_fwd_q + 16'd1 == TARGET) begin
                        state_d = ST_DRAIN;
                    end
                end
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else if (timeout_hit) begin
                    aborted_d = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                end
                if (!gate_open) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == SETTLE_LAST) begin
                    res_count_d = det_count;
                    res_ok_d    = det_ok;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and run registers; done is a registered pulse on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pkt_fwd_q   <= '0;
            cnt_q       <= '0;
            res_count_q <= '0;
            res_ok_q    <= '0;
            aborted_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_fwd_q   <= pkt_fwd_d;
            cnt_q       <= cnt_d;
            res_count_q <= res_count_d;
            res_ok_q    <= res_ok_d;
            aborted_q   <= aborted_d;
            done_q      <= (state_d == ST_DONE) && (state_q != ST_DONE);
        end
    end

    assign det_rst      = rst | (state_q == ST_CLEAR);
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign state        = state_q;
    assign pkt_fwd      = pkt_fwd_q;
    assign result_count = res_count_q;
    assign result_ok    = res_ok_q;
    assign result_err   = res_count_q - res_ok_q;

endmodule

// File: tb/tb_err_test_ctrl.sv
// ---------------------------------------------------------------------------
// tb_err_test_ctrl
// Scoreboard bench for err_test_ctrl (PKT_TARGET=5). Stimulus pushes the
// expected forwarded bursts and run results into queues; a negedge monitor
// pops and compares whenever the DUT forwards a burst or pulses done.
// A small detect_errors stand-in counts forwarded packets and treats a
// packet as ok when it is exactly 12 bytes long.
// ---------------------------------------------------------------------------
module tb_err_test_ctrl;

    localparam int TARGET = 5;

    logic        clk = 1'b0;
    logic        rst, start, abort, rxEnIn;
    logic [7:0]  rxDataIn;
    logic        rxEnOut, detRst, busy, done, aborted;
    logic [7:0]  rxDataOut;
    logic [31:0] detCount, detOk, resCount, resOk, resErr;
    logic [15:0] pktFwd;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct { int len; int idx; int startCyc; } pkt_t;
    typedef struct { logic [31:0] cnt; logic [31:0] ok; logic [15:0] fwd; logic ab; } res_t;
    pkt_t pktQ[$];
    res_t resQ[$];

    err_test_ctrl #(
        .PKT_TARGET     (TARGET),
        .CLEAR_CYCLES   (2),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .rx_en_in     (rxEnIn),
        .rx_data_in   (rxDataIn),
        .rx_en_out    (rxEnOut),
        .rx_data_out  (rxDataOut),
        .det_rst      (detRst),
        .det_count    (detCount),
        .det_ok       (detOk),
        .pkt_fwd      (pktFwd),
        .result_count (resCount),
        .result_ok    (resOk),
        .result_err   (resErr),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .state        (state)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // detect_errors stand-in: count on burst start, ok on a 12-byte burst end
    logic prevOut;
    int   lenAcc;
    always @(posedge clk) begin
        if (detRst) begin
            detCount <= 32'd0;
            detOk    <= 32'd0;
            prevOut  <= 1'b0;
            lenAcc   <= 0;
        end else begin
            prevOut <= rxEnOut;
            if (rxEnOut) lenAcc <= prevOut ? lenAcc + 1 : 1;
            if (rxEnOut && !prevOut) detCount <= detCount + 32'd1;
            if (!rxEnOut && prevOut && lenAcc == 12) detOk <= detOk + 32'd1;
        end
    end

    function automatic logic [7:0] pktByte(input int i, input int idx);
        return (i == 3) ? 8'(idx) : 8'(8'hA0 + i);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rxEnIn = 1'b0; rxDataIn = 8'h00; start = 1'b0; abort = 1'b0; rst = 1'b0;
        end
    endtask

    // One packet of len bytes followed by a 10-cycle gap. startAt/abortAt/
    // rstAt pulse the control input on that byte (-1 = never). fwd means the
    // packet is expected on rx_en_out; rstAt truncates the expected burst.
    task automatic applyStimulus(input int len, input int idx, input bit fwd,
                                 input int startAt, input int abortAt, input int rstAt);
        pkt_t p;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (i == 0 && fwd) begin
                p.len      = (rstAt >= 0) ? rstAt : len;
                p.idx      = idx;
                p.startCyc = cyc + 1;
                pktQ.push_back(p);
            end
            rxEnIn   = 1'b1;
            rxDataIn = pktByte(i, idx);
            start    = (i == startAt);
            abort    = (i == abortAt);
            rst      = (i == rstAt);
            if (i == rstAt) begin
                @(negedge clk);
                checkOutput("det_rst_during_rst", {31'd0, detRst}, 32'd1);
            end
            if (rstAt >= 0 && i == rstAt + 1) begin
                @(negedge clk);
                checkOutput("rst_state", {29'd0, state}, 32'd0);
                checkOutput("rst_rx_en_out", {31'd0, rxEnOut}, 32'd0);
                checkOutput("rst_busy", {31'd0, busy}, 32'd0);
                checkOutput("rst_pkt_fwd", {16'd0, pktFwd}, 32'd0);
                checkOutput("rst_result_count", resCount, 32'd0);
                checkOutput("rst_result_ok", resOk, 32'd0);
                checkOutput("rst_result_err", resErr, 32'd0);
            end
        end
        idleCycles(10);
    endtask

    task automatic pulseStart(input bit withAbort);
        @(posedge clk); #1;
        start = 1'b1; abort = withAbort;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic pushResult(input int c, input int o, input int f, input bit ab);
        res_t r;
        r.cnt = 32'(c); r.ok = 32'(o); r.fwd = 16'(f); r.ab = ab;
        resQ.push_back(r);
    endtask

    // Monitor: forwarded bursts, done results, HOLD length, det_rst length
    initial begin
        pkt_t cur;
        res_t r;
        bit   inBurst = 0;
        bit   haveCur = 0;
        int   burstLen = 0;
        int   holdLen = 0;
        int   detRstLen = 0;
        logic prevDone = 1'b0;
        logic [2:0] prevState = 3'd0;
        forever begin
            @(negedge clk);
            if (rxEnOut === 1'b1) begin
                if (!inBurst) begin
                    inBurst  = 1;
                    burstLen = 0;
                    checkOutput("burst_expected", {31'd0, pktQ.size() > 0}, 32'd1);
                    haveCur = (pktQ.size() > 0);
                    if (haveCur) begin
                        cur = pktQ[0];
                        checkOutput("burst_latency", 32'(cyc), 32'(cur.startCyc));
                    end
                end
                if (haveCur) checkOutput("fwd_byte", {24'd0, rxDataOut}, {24'd0, pktByte(burstLen, cur.idx)});
                burstLen++;
            end else begin
                checkOutput("idle_data_zero", {24'd0, rxDataOut}, 32'd0);
                if (inBurst) begin
                    inBurst = 0;
                    if (haveCur) begin
                        void'(pktQ.pop_front());
                        checkOutput("burst_len", 32'(burstLen), 32'(cur.len));
                    end
                end
            end

            if (done === 1'b1) begin
                checkOutput("done_single", {31'd0, prevDone}, 32'd0);
                checkOutput("done_expected", {31'd0, resQ.size() > 0}, 32'd1);
                if (resQ.size() > 0) begin
                    r = resQ.pop_front();
                    checkOutput("result_count", resCount, r.cnt);
                    checkOutput("result_ok", resOk, r.ok);
                    checkOutput("result_err", resErr, r.cnt - r.ok);
                    checkOutput("result_pkt_fwd", {16'd0, pktFwd}, {16'd0, r.fwd});
                    checkOutput("result_aborted", {31'd0, aborted}, {31'd0, r.ab});
                end
            end
            prevDone = done;

            if (state == 3'd5) begin
                holdLen++;
            end else if (prevState == 3'd5) begin
                checkOutput("hold_len", 32'(holdLen), 32'd4);
                checkOutput("hold_exit_state", {29'd0, state}, 32'd6);
                holdLen = 0;
            end
            prevState = state;

            if (detRst === 1'b1 && rst === 1'b0) begin
                detRstLen++;
            end else if (detRstLen > 0) begin
                checkOutput("det_rst_len", 32'(detRstLen), 32'd2);
                detRstLen = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; rxEnIn = 1'b0; rxDataIn = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_det_rst", {31'd0, detRst}, 32'd1);
        idleCycles(2);
        @(negedge clk);
        checkOutput("reset_state", {29'd0, state}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_aborted", {31'd0, aborted}, 32'd0);
        checkOutput("reset_pkt_fwd", {16'd0, pktFwd}, 32'd0);
        checkOutput("reset_result_count", resCount, 32'd0);
        checkOutput("reset_result_err", resErr, 32'd0);
        checkOutput("reset_rx_en_out", {31'd0, rxEnOut}, 32'd0);
        checkOutput("reset_det_rst_low", {31'd0, detRst}, 32'd0);

        // Run 1: 7 packets, packet 2 short; only the first 5 are forwarded
        pushResult(5, 4, 5, 1'b0);
        pulseStart(1'b0);
        @(negedge clk);
        checkOutput("run1_clear_state", {29'd0, state}, 32'd1);
        checkOutput("run1_busy", {31'd0, busy}, 32'd1);
        idleCycles(4);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus((k == 2) ? 8 : 12, k, k <= TARGET, -1, -1, -1);
        end
        @(negedge clk);
        checkOutput("run1_final_state", {29'd0, state}, 32'd6);
        checkOutput("run1_pkt_fwd_sat", {16'd0, pktFwd}, 32'd5);

        // Run 2: start mid-packet; that packet is skipped
        pushResult(5, 5, 5, 1'b0);
        applyStimulus(12, 20, 1'b0, 5, -1, -1);
        for (int k = 21; k <= 25; k++) begin
            applyStimulus(12, k, 1'b1, -1, -1, -1);
        end

        // Run 3: abort during byte 6 of packet 3; packet 3 still completes
        pushResult(3, 3, 3, 1'b1);
        pulseStart(1'b0);
        idleCycles(4);
        applyStimulus(12, 31, 1'b1, -1, -1, -1);
        applyStimulus(12, 32, 1'b1, -1, -1, -1);
        applyStimulus(12, 33, 1'b1, -1, 6, -1);
        applyStimulus(12, 34, 1'b0, -1, -1, -1);

        // Run 4: new start clears aborted; abort in CLEAR keeps old results
        pushResult(3, 3, 0, 1'b1);
        pulseStart(1'b0);
        @(negedge clk);
        checkOutput("run4_aborted_cleared", {31'd0, aborted}, 32'd0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("run4_abort_clear_state", {29'd0, state}, 32'd6);
        checkOutput("run4_aborted", {31'd0, aborted}, 32'd1);
        idleCycles(3);

        // Run 5: start and abort together in DONE (start wins), then rst mid-packet
        pulseStart(1'b1);
        @(negedge clk);
        checkOutput("run5_start_wins_state", {29'd0, state}, 32'd1);
        checkOutput("run5_start_wins_aborted", {31'd0, aborted}, 32'd0);
        idleCycles(4);
        applyStimulus(12, 51, 1'b1, -1, -1, -1);
        applyStimulus(12, 52, 1'b1, -1, -1, -1);
        applyStimulus(12, 53, 1'b1, -1, -1, 4);

        // Run 6: two packets then silence
`ifdef RUN_TIMEOUT_EN
        pushResult(2, 2, 2, 1'b1);
`endif
        pulseStart(1'b0);
        idleCycles(4);
        applyStimulus(12, 61, 1'b1, -1, -1, -1);
        applyStimulus(12, 62, 1'b1, -1, -1, -1);
        idleCycles(80);
        @(negedge clk);
        checkOutput("run6_pkt_fwd", {16'd0, pktFwd}, 32'd2);
`ifdef RUN_TIMEOUT_EN
        checkOutput("run6_timeout_state", {29'd0, state}, 32'd6);
        checkOutput("run6_timeout_aborted", {31'd0, aborted}, 32'd1);
`else
        checkOutput("run6_wait_state", {29'd0, state}, 32'd3);
        checkOutput("run6_not_aborted", {31'd0, aborted}, 32'd0);
`endif

        idleCycles(5);
        checkOutput("pending_bursts", 32'(pktQ.size()), 32'd0);
        checkOutput("pending_results", 32'(resQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/err_test_ctrl.md
Name: err_test_ctrl

Overview:
Run controller for the detect_errors receive-side error counter. Frames a measurement run:
- pulses the detector's reset;
- waits for an inter-packet gap, then forwards exactly PKT_TARGET whole packets from the MAC receive stream into the detector;
- lets the detector outputs settle and latches its count/ok totals as a run result.
Sits between the GMII/MAC RX byte stream and detect_errors.

Parameters:
PKT_TARGET, 300, packets forwarded per run (1..2^16-1)
CLEAR_CYCLES, 2, det_rst pulse length in cycles (>=1)
SETTLE_CYCLES, 4, cycles after last forwarded byte before latching detector outputs
TIMEOUT_CYCLES, 1000000, idle-gap watchdog limit (used only with RUN_TIMEOUT_EN)

Ports:
clk  in  1  125 MHz system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins a run (ignored unless IDLE or DONE)
abort  in  1  one-cycle pulse; ends the run early
rx_en_in  in  1  RX byte-valid from MAC
rx_data_in  in  8  RX byte from MAC
rx_en_out  out  1  gated byte-valid to detect_errors
rx_data_out  out  8  gated byte to detect_errors (0 when rx_en_out=0)
det_rst  out  1  reset to detect_errors
det_count  in  32  detect_errors count
det_ok  in  32  detect_errors ok
pkt_fwd  out  16  packets forwarded this run
result_count  out  32  latched det_count
result_ok  out  32  latched det_ok
result_err  out  32  result_count - result_ok (mod 2^32)
busy  out  1  high in CLEAR/ARM/RUN/DRAIN/HOLD
done  out  1  one-cycle pulse on entry to DONE
aborted  out  1  sticky; run ended by abort (or timeout); cleared by start
state  out  3  current state encoding

Behaviour:
- Reset values: rx_en_out=0, rx_data_out=0, pkt_fwd=0, result_*=0, busy=0, done=0, aborted=0, state=IDLE. det_rst=1 while rst=1.
- The forward path is registered: rx_en_out/rx_data_out equal the previous cycle's rx_en_in/rx_data_in when the gate is open. Latency is 1 cycle.
- Packet start is detected as rx_en_in=1 with prev rx_en_in=0. The gate opens only on a start edge and stays open until rx_en_in falls, so only whole packets are forwarded.
- IDLE(0): waits for start. On start: clear pkt_fwd and aborted, go to CLEAR.
- CLEAR(1): det_rst=1 for CLEAR_CYCLES cycles, then go to ARM.
- ARM(2): if rx_en_in=0, go to RUN. A packet already in flight is never forwarded.
- RUN(3):
  - On each start edge: open the gate and increment pkt_fwd.
  - When pkt_fwd reaches PKT_TARGET after a start edge, go to DRAIN.
- DRAIN(4): wait until the gate closes (packet end), then go to HOLD.
- HOLD(5): count SETTLE_CYCLES, then latch det_count/det_ok and go to DONE.
- DONE(6): done=1 for one cycle; results held. On start: go to CLEAR (pkt_fwd cleared; results keep old values until the next latch).
- abort in CLEAR/ARM: set aborted, go to DONE without latching; results hold their previous values.
- abort in RUN/DRAIN: set aborted, go to DRAIN (the current packet finishes), then HOLD, then latch.
- abort in IDLE/DONE is ignored.
- start during busy is ignored. If start and abort arrive together in IDLE/DONE, start wins.
- rst mid-run: everything returns to reset values at the next edge, the gate closes immediately, det_rst=1.
- A start edge in RUN on the same cycle that makes pkt_fwd==PKT_TARGET is forwarded. Start edges after that are not.
- pkt_fwd saturates at PKT_TARGET.

Optional Feature:
RUN_TIMEOUT_EN:
- Defined: a watchdog counter resets on every rx_en_in start edge and on entry to ARM. If it reaches TIMEOUT_CYCLES in ARM or RUN, aborted is set and the FSM goes to HOLD (latches partial results).
- Undefined: no watchdog; ARM/RUN wait indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package err_test_pkg holds:
  - the 3-bit state localparams (IDLE=0, CLEAR=1, ARM=2, RUN=3, DRAIN=4, HOLD=5, DONE=6);
  - the byte width (8) and counter width (32).
- Sub-module pkt_gate: start-edge detect, open/close gate, registered forward path. Outputs gate_open and a start_fwd pulse; the FSM drives its enable.

Test Plan:
1. rst, start, 300 packets of 12 bytes with aux byte = index at offset 3, 10-cycle gaps -> exactly 300 rx_en_out bursts of 12 bytes each, delayed 1 cycle; pkt_fwd=300; result_count=300, result_ok=300 (model), result_err=0; done pulse once.
2. start issued mid-packet -> that packet is not forwarded; the first rx_en_out rises 1 cycle after the next packet's start; det_rst high 2 cycles after start.
3. PKT_TARGET=5, 8 packets sent -> only packets 1-5 forwarded; packet 6 sees rx_en_out=0; state goes RUN->DRAIN->HOLD->DONE, with HOLD lasting 4 cycles.
4. abort during byte 6 of packet 3 -> packet 3 completes (12 bytes out); aborted=1; result latched with pkt_fwd=3; a new start clears aborted.
5. rst asserted during RUN at byte 4 -> rx_en_out=0 next cycle, state=IDLE, det_rst=1, all results 0.
6. RUN_TIMEOUT_EN with TIMEOUT_CYCLES=50; start, 2 packets, then silence -> aborted=1 50 cycles after the 2nd start edge; pkt_fwd=2; done pulses. Without the macro: state stays RUN.
